// File: rtl/div47_result_checker_if.sv
// Handshake bundle for the divide-by-47 result checker.
//   slave  : checker side (accepts X/Q/R tuples, produces checked Q/R/err)
//   master : environment side (drives tuples, consumes results)
// Signals:
//   in_valid/in_ready   tuple handshake
//   in_x/in_q/in_r      dividend, quotient and remainder under test
//   out_valid/out_ready result handshake
//   out_q/out_r/out_err captured quotient, remainder and mismatch flag
interface div47_result_checker_if #(
   parameter int unsigned XW = 60,
   parameter int unsigned QW = 55,
   parameter int unsigned RW = 6
) ();
   logic          in_valid;
   logic          in_ready;
   logic [XW-1:0] in_x;
   logic [QW-1:0] in_q;
   logic [RW-1:0] in_r;
   logic          out_valid;
   logic          out_ready;
   logic [QW-1:0] out_q;
   logic [RW-1:0] out_r;
   logic          out_err;

   modport slave (
      input  in_valid, in_x, in_q, in_r, out_ready,
      output in_ready, out_valid, out_q, out_r, out_err
   );

   modport master (
      output in_valid, in_x, in_q, in_r, out_ready,
      input  in_ready, out_valid, out_q, out_r, out_err
   );
endinterface

// File: rtl/div47_result_checker.sv
// Self-check stage behind the divide-by-47 datapath. Captures one (X, Q, R) tuple per
// handshake, rebuilds Q*DIVISOR + R with a shift-add over the RW divisor bits (one bit per
// cycle), flags a mismatch against X or an out-of-range remainder, and forwards Q/R/err.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        div47_result_checker_if.slave (tuple in, checked result out)
//   err_count  16-bit saturating count of failing results handed downstream
//              (present only when DIV47_CHK_ERRCNT_EN is defined)
// Configuration macro: DIV47_CHK_ERRCNT_EN
module div47_result_checker #(
   parameter int unsigned XW      = 60,
   parameter int unsigned QW      = 55,
   parameter int unsigned RW      = 6,
   parameter int unsigned DIVISOR = 47
) (
   input  logic                         clk,
   input  logic                         rst_n,
`ifdef DIV47_CHK_ERRCNT_EN
   output logic [15:0]                  err_count,
`endif
   div47_result_checker_if.slave        bus
);

   // One guard bit above QW+RW so Q*DIVISOR + R can never wrap.
   localparam int unsigned AccW = QW + RW + 1;
   localparam int unsigned IdxW = (RW > 1) ? $clog2(RW) : 1;
   localparam logic [RW-1:0] DivBits = RW'(DIVISOR);

   typedef enum logic [1:0] {StIdle, StAcc, StCmp, StOut} state_e;

   state_e          state_q, state_d;
   logic [XW-1:0]   x_q, x_d;
   logic [QW-1:0]   q_q, q_d;
   logic [RW-1:0]   r_q, r_d;
   logic [AccW-1:0] acc_q, acc_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic            out_valid_q, out_valid_d;
   logic [QW-1:0]   out_q_q, out_q_d;
   logic [RW-1:0]   out_r_q, out_r_d;
   logic            out_err_q, out_err_d;

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      q_d         = q_q;
      r_d         = r_q;
      acc_d       = acc_q;
      idx_d       = idx_q;
      out_valid_d = out_valid_q;
      out_q_d     = out_q_q;
      out_r_d     = out_r_q;
      out_err_d   = out_err_q;
      case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               x_d     = bus.in_x;
               q_d     = bus.in_q;
               r_d     = bus.in_r;
               acc_d   = AccW'(bus.in_r);
               idx_d   = '0;
               state_d = StAcc;
            end
         end
         StAcc: begin
            if (DivBits[idx_q]) begin
               acc_d = acc_q + (AccW'(q_q) << idx_q);
            end
            idx_d = idx_q + IdxW'(1);
            if (idx_q == IdxW'(RW - 1)) begin
               state_d = StCmp;
            end
         end
         StCmp: begin
            out_q_d     = q_q;
            out_r_d     = r_q;
            out_err_d   = (acc_q != AccW'(x_q)) || (r_q >= DivBits);
            out_valid_d = 1'b1;
            state_d     = StOut;
         end
         StOut: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         x_q         <= '0;
         q_q         <= '0;
         r_q         <= '0;
         acc_q       <= '0;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         out_q_q     <= '0;
         out_r_q     <= '0;
         out_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         q_q         <= q_d;
         r_q         <= r_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         out_valid_q <= out_valid_d;
         out_q_q     <= out_q_d;
         out_r_q     <= out_r_d;
         out_err_q   <= out_err_d;
      end
   end

   // No bypass: a new tuple is only taken once the FSM is back in idle.
   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = out_valid_q;
   assign bus.out_q     = out_q_q;
   assign bus.out_r     = out_r_q;
   assign bus.out_err   = out_err_q;

`ifdef DIV47_CHK_ERRCNT_EN
   logic [15:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (out_valid_q && bus.out_ready && out_err_q && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_count = err_cnt_q;
`else
   // Failure counting disabled: out_err is the only report of a bad tuple.
`endif

endmodule
